pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter register and fetch-request sequencer for the single-cycle RISC-V core. It consumes the branch/jump target from the target adder (`PCTarget`) and the redirect select (`PCSrc`), then issues instruction-fetch addresses to instruction memory over a valid/ready handshake. It holds the address stable while a request is outstanding and queues one redirect that arrives during a memory wait. It sits between the datapath's target/next-PC logic and the instruction-memory port.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `TRAP_VEC`, 32'h0000_0100, fetch address after a misaligned redirect (only with the macro)
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low; one clock domain only
- `PCTarget`  in  32  branch/jump target from the target adder
- `PCSrc`  in  1  redirect request; take `PCTarget` this cycle
- `Stall`  in  1  core stall; no new fetch is issued while high
- `FetchValid`  out  1  fetch request valid (registered)
- `FetchReady`  in  1  instruction memory accepts the request
- `PC`  out  32  current fetch address; drives imem address (registered)
- `PCPlus4`  out  32  `PC + 4`, combinational, modulo 2^32
- `RedirPending`  out  1  a redirect is queued behind the outstanding fetch
- `MisalignErr`  out  1  one-cycle pulse on a misaligned redirect (only with the macro; tied 0 otherwise)

## Operation
- States:
  - `IDLE`: in reset and for the first cycle after reset.
  - `ISSUE`: `FetchValid`=1, no redirect queued.
  - `PEND`: `FetchValid`=1, redirect queued.
  - `HOLD`: `FetchValid`=0 because of `Stall`.
  - `TRAP`: one cycle; only with the macro.
- Fire = `FetchValid & FetchReady`.
- IDLE -> ISSUE if `Stall`=0, otherwise IDLE -> HOLD. `PC` stays `RESET_PC`.
- ISSUE, no fire:
  - `PC` is held.
  - If `PCSrc`=1, latch `PCTarget` into the pending register and go to PEND.
- ISSUE/PEND on fire: next `PC` uses this priority:
  1. `PCSrc` ? `PCTarget`
  2. pending ? pending register
  3. `PCPlus4`
  - Pending is cleared.
  - Next state is ISSUE if `Stall`=0, otherwise HOLD.
- PEND, no fire:
  - If `PCSrc`=1, overwrite the pending register (latest redirect wins).
  - `PC` is held.
- HOLD:
  - `PCSrc`=1 loads `PC` <= `PCTarget` directly; no request is outstanding.
  - HOLD -> ISSUE when `Stall`=0.
- `FetchValid` never drops while a request is unfired, and `PC` never changes while `FetchValid`=1 and unfired.
- `Stall` asserted during ISSUE/PEND does not cancel the outstanding request; it takes effect after fire.
- Arithmetic is 32-bit unsigned with wrap: `PC`=32'hFFFF_FFFC gives `PCPlus4`=32'h0000_0000.
- `rst_n` low mid-request immediately aborts it. The pending redirect is discarded.

## Timing
- Reset values: `PC`=`RESET_PC`, `FetchValid`=0, `RedirPending`=0, `MisalignErr`=0, state IDLE.
- First `FetchValid`=1 appears on the 2nd rising edge after `rst_n` release, provided `Stall`=0.
- Fire-to-next-address latency is 1 cycle, giving back-to-back fetches at one per cycle while `FetchReady`=1.
- A redirect in the same cycle as fire takes effect on the next edge, with no bubble.
- A redirect during a wait takes effect on the edge after fire.
- `RedirPending` is registered and mirrors state PEND.

## Configuration
- Macro: `PC_FETCH_MISALIGN_TRAP_EN`.
- Defined: a redirect (direct, or applied from pending) with `PCTarget[1:0]`≠0 is handled as follows:
  - It sends the FSM to TRAP for one cycle with `MisalignErr`=1 and `FetchValid`=0.
  - It then loads `PC`=`TRAP_VEC` and continues to ISSUE (or HOLD if `Stall`).
- Undefined:
  - Bits [1:0] of every redirect target are forced to 0 and no trap occurs.
  - `MisalignErr` is constant 0 and the TRAP state is not built.

## Test plan
- Reset with `FetchReady`=1, `Stall`=0 -> `PC` sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, with the first valid on the 2nd edge after release.
- `FetchReady`=0 for 3 cycles at `PC`=0x8 while `PCSrc`=1 with `PCTarget`=0x40, then 0x80 -> `PC` held at 0x8, `RedirPending`=1; after fire, next `PC`=0x80.
- Redirect coincident with fire at `PC`=0x10 with `PCTarget`=0x200 -> next `PC`=0x200 with no bubble.
- `Stall`=1 at `PC`=0x20 while `FetchReady`=0 -> request held until fire; then `FetchValid`=0. During HOLD, `PCSrc` with target 0x300 -> resumes at 0x300.
- Macro on: redirect to 0x102 -> `MisalignErr` pulses 1 cycle, then `PC`=`TRAP_VEC` 0x100. Macro off: same stimulus -> `PC`=0x100 via masking, no pulse.
- `rst_n` dropped while in PEND -> `PC`=`RESET_PC` and `FetchValid`=0 immediately, with no pending redirect applied after release.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus of the PC sequencer: redirect inputs from the datapath and the
// valid/ready instruction-memory request port.
interface pc_fetch_ctrl_if;
   logic [31:0] PCTarget;
   logic        PCSrc;
   logic        Stall;
   logic        FetchValid;
   logic        FetchReady;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        RedirPending;
   logic        MisalignErr;

   modport master (
      input  PCTarget, PCSrc, Stall, FetchReady,
      output FetchValid, PC, PCPlus4, RedirPending, MisalignErr
   );

   modport slave (
      output PCTarget, PCSrc, Stall, FetchReady,
      input  FetchValid, PC, PCPlus4, RedirPending, MisalignErr
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request sequencer with one queued redirect.
// Define PC_FETCH_MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_VEC instead of masking them.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_FETCH_MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
   input logic             clk,
   input logic             rst_n,
   pc_fetch_ctrl_if.master fetchBus
);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {IDLE, ISSUE, PEND, HOLD, TRAP} fetchState_e;
`else
   typedef enum logic [1:0] {IDLE, ISSUE, PEND, HOLD} fetchState_e;
`endif

   fetchState_e state;
   fetchState_e nextState;
   logic [31:0] pcReg;
   logic [31:0] pendReg;
   logic [31:0] nextPc;
   logic [31:0] nextPend;
   logic [31:0] pcPlus4;
   logic [31:0] redirAddr;
   logic [31:0] fireAddr;
   logic        resetDone;
   logic        fetchValid;
   logic        fire;

   assign pcPlus4  = pcReg + 32'd4;
   assign fire     = fetchValid & fetchBus.FetchReady;
   assign fireAddr = fetchBus.PCSrc ? redirAddr : ((state == PEND) ? pendReg : pcPlus4);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
   logic fireTrap;
   logic holdTrap;

   // Targets are kept raw so a misaligned one can be caught when it is applied.
   assign redirAddr = fetchBus.PCTarget;
   assign fireTrap  = (fetchBus.PCSrc || (state == PEND)) && (fireAddr[1:0] != 2'b00);
   assign holdTrap  = fetchBus.PCSrc && (redirAddr[1:0] != 2'b00);
`else
   logic unusedTargetLsbs;

   assign redirAddr        = {fetchBus.PCTarget[31:2], 2'b00};
   assign unusedTargetLsbs = ^fetchBus.PCTarget[1:0];
`endif

   // resetDone keeps IDLE for one full cycle after the first edge out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pcReg     <= RESET_PC;
         pendReg   <= '0;
         resetDone <= 1'b0;
      end else begin
         state     <= nextState;
         pcReg     <= nextPc;
         pendReg   <= nextPend;
         resetDone <= 1'b1;
      end
   end

   // An unfired request always stays in ISSUE/PEND; Stall only matters once it fires.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (resetDone) begin
               nextState = fetchBus.Stall ? HOLD : ISSUE;
            end
         end
         ISSUE, PEND: begin
            if (fire) begin
               nextState = fetchBus.Stall ? HOLD : ISSUE;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
               if (fireTrap) begin
                  nextState = TRAP;
               end
`endif
            end else if (fetchBus.PCSrc) begin
               nextState = PEND;
            end
         end
         HOLD: begin
            if (!fetchBus.Stall) begin
               nextState = ISSUE;
            end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            if (holdTrap) begin
               nextState = TRAP;
            end
`endif
         end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
         TRAP: begin
            nextState = fetchBus.Stall ? HOLD : ISSUE;
         end
`endif
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // PC only moves on fire, on a direct redirect while no request is out, or leaving TRAP.
   always_comb begin
      fetchValid = (state == ISSUE) || (state == PEND);
      nextPc     = pcReg;
      nextPend   = pendReg;
      case (state)
         ISSUE, PEND: begin
            if (fire) begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
               if (!fireTrap) begin
                  nextPc = fireAddr;
               end
`else
               nextPc = fireAddr;
`endif
            end else if (fetchBus.PCSrc) begin
               nextPend = redirAddr;
            end
         end
         HOLD: begin
            if (fetchBus.PCSrc) begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
               if (!holdTrap) begin
                  nextPc = redirAddr;
               end
`else
               nextPc = redirAddr;
`endif
            end
         end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
         TRAP: begin
            nextPc = TRAP_VEC;
         end
`endif
         default: begin
            nextPc = pcReg;
         end
      endcase
   end

   assign fetchBus.FetchValid   = fetchValid;
   assign fetchBus.PC           = pcReg;
   assign fetchBus.PCPlus4      = pcPlus4;
   assign fetchBus.RedirPending = (state == PEND);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
   assign fetchBus.MisalignErr  = (state == TRAP);
`else
   assign fetchBus.MisalignErr  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed fetch scenarios followed by random
// traffic, all checked against a transaction-level model of the fetch sequencer.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

   logic clk;
   logic rst_n;

   pc_fetch_ctrl_if bus();

   pc_fetch_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetchBus (bus)
   );

   int compared;
   int mismatched;

   // Reference model: expected PC, whether a request is on the bus, queued redirects,
   // edges seen since reset release, and a pending trap cycle.
   logic [31:0] mPc;
   logic        mValid;
   logic [31:0] mPend[$];
   int          mBoot;
   logic        mTrap;

   logic [31:0] rTarget;
   logic        rSrc;
   logic        rStall;
   logic        rReady;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      checkValue("PC", bus.PC, mPc);
      checkValue("PCPlus4", bus.PCPlus4, mPc + 32'd4);
      checkValue("FetchValid", {31'd0, bus.FetchValid}, {31'd0, mValid});
      checkValue("RedirPending", {31'd0, bus.RedirPending}, {31'd0, (mPend.size() != 0)});
      checkValue("MisalignErr", {31'd0, bus.MisalignErr}, {31'd0, mTrap});
   endtask

   // One clock edge of fetch behaviour, expressed as request/redirect rules.
   task automatic modelStep(input logic pcSrc, input logic [31:0] target, input logic stall, input logic ready);
      logic [31:0] redir;
      logic [31:0] dest;
      logic        redirUsed;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      redir = target;
`else
      redir = {target[31:2], 2'b00};
`endif
      if (mBoot < 2) begin
         mBoot++;
         if (mBoot == 2) mValid = !stall;
         return;
      end
      if (mTrap) begin
         mTrap  = 1'b0;
         mPc    = TRAP_VEC;
         mValid = !stall;
         return;
      end
      if (mValid) begin
         if (ready) begin
            redirUsed = pcSrc || (mPend.size() != 0);
            dest = pcSrc ? redir : ((mPend.size() != 0) ? mPend[0] : mPc + 32'd4);
            mPend.delete();
            if (redirUsed && (dest[1:0] != 2'b00)) begin
               mTrap  = 1'b1;
               mValid = 1'b0;
            end else begin
               mPc    = dest;
               mValid = !stall;
            end
         end else if (pcSrc) begin
            mPend.delete();
            mPend.push_back(redir);
         end
      end else begin
         if (pcSrc && (redir[1:0] != 2'b00)) begin
            mTrap = 1'b1;
         end else begin
            if (pcSrc) mPc = redir;
            if (!stall) mValid = 1'b1;
         end
      end
   endtask

   // Called at a falling edge: drive inputs, advance model on the rising edge, check on the next falling edge.
   task automatic applyStimulus(input logic pcSrc, input logic [31:0] target, input logic stall, input logic ready);
      bus.PCSrc      = pcSrc;
      bus.PCTarget   = target;
      bus.Stall      = stall;
      bus.FetchReady = ready;
      @(posedge clk);
      modelStep(pcSrc, target, stall, ready);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      #1;
      mPc    = RESET_PC;
      mValid = 1'b0;
      mPend.delete();
      mBoot  = 0;
      mTrap  = 1'b0;
      checkOutput();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      compared       = 0;
      mismatched     = 0;
      rst_n          = 1'b0;
      bus.PCSrc      = 1'b0;
      bus.PCTarget   = '0;
      bus.Stall      = 1'b0;
      bus.FetchReady = 1'b0;
      @(negedge clk);
      resetDut();

      $display("[TB] reset release and sequential fetch");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkValue("boot_idle_valid", {31'd0, bus.FetchValid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkValue("first_valid", {31'd0, bus.FetchValid}, 32'd1);
      checkValue("first_pc", bus.PC, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkValue("seq_pc8", bus.PC, 32'h8);

      $display("[TB] redirects queued during memory wait");
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h80, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkValue("wait_pc_held", bus.PC, 32'h8);
      checkValue("wait_pending", {31'd0, bus.RedirPending}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkValue("latest_redirect", bus.PC, 32'h80);

      $display("[TB] redirect coincident with fire");
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
      checkValue("fire_redirect_pc", bus.PC, 32'h200);
      checkValue("fire_redirect_valid", {31'd0, bus.FetchValid}, 32'd1);

      $display("[TB] stall with outstanding request, redirect while held");
      applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkValue("stall_keeps_request", {31'd0, bus.FetchValid}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkValue("hold_no_valid", {31'd0, bus.FetchValid}, 32'd0);
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkValue("hold_resume_pc", bus.PC, 32'h300);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

      $display("[TB] misaligned redirect");
      applyStimulus(1'b1, 32'h102, 1'b0, 1'b1);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      checkValue("misalign_pulse", {31'd0, bus.MisalignErr}, 32'd1);
`else
      checkValue("misalign_masked", {31'd0, bus.MisalignErr}, 32'd0);
`endif
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkValue("misalign_pc", bus.PC, 32'h100);

      $display("[TB] address wrap");
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      checkValue("wrap_plus4", bus.PCPlus4, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkValue("wrap_pc", bus.PC, 32'h0);

      $display("[TB] reset while a redirect is queued");
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b0);
      resetDut();
      checkValue("abort_valid", {31'd0, bus.FetchValid}, 32'd0);
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkValue("no_stale_redirect", bus.PC, 32'h4);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         rTarget = $urandom;
         rSrc    = ($urandom_range(3) == 0);
         rStall  = ($urandom_range(4) == 0);
         rReady  = ($urandom_range(1) == 0);
         if (i == 200) resetDut();
         applyStimulus(rSrc, rTarget, rStall, rReady);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
